// File: rtl/cpu_pkg.sv
// Shared CPU types: decoder control encodings, condition codes and sequencer state.
package cpu_pkg;

    typedef logic [7:0]  opcode_t;
    typedef logic [7:0]  reg8_t;
    typedef logic [15:0] reg16_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_ADC = 3'd1,
        ALU_SUB = 3'd2,
        ALU_SBC = 3'd3,
        ALU_AND = 3'd4,
        ALU_XOR = 3'd5,
        ALU_OR  = 3'd6,
        ALU_CP  = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        S_ACC_NONE = 2'd0,
        S_ACC_REG  = 2'd1,
        S_ACC_MEM  = 2'd2,
        S_ACC_IMM  = 2'd3
    } s_acc_t;

    typedef enum logic [1:0] {
        IDU_NONE = 2'd0,
        IDU_INC  = 2'd1,
        IDU_DEC  = 2'd2,
        IDU_PASS = 2'd3
    } idu_mode_t;

    // Encoding matches opcode[4:3] of the conditional instructions.
    typedef enum logic [1:0] {
        CC_NZ = 2'd0,
        CC_Z  = 2'd1,
        CC_NC = 2'd2,
        CC_C  = 2'd3
    } cc_t;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        EXEC = 2'd1,
        TRAP = 2'd2
    } seq_state_t;

endpackage

// File: rtl/cpu_sequencer_if.sv
// External memory bus handshake between the sequencer (master) and memory (slave).
interface cpu_sequencer_if;
    import cpu_pkg::*;

    logic  req;
    logic  we;
    logic  ack;
    reg8_t rdata;

    modport master (output req, output we, input ack, input rdata);
    modport slave  (input req, input we, output ack, output rdata);

endinterface

// File: rtl/cpu_sequencer_cc_eval.sv
// Condition-code evaluator shared by conditional step sequencing and branch decoding.
module cc_eval
    import cpu_pkg::*;
(
    input  cc_t  cc,
    input  logic flag_z,
    input  logic flag_c,
    output logic satisfied
);

    // Select the flag test named by the condition code.
    always_comb begin
        satisfied = 1'b0;
        case (cc)
            CC_NZ:   satisfied = ~flag_z;
            CC_Z:    satisfied = flag_z;
            CC_NC:   satisfied = ~flag_c;
            CC_C:    satisfied = flag_c;
            default: satisfied = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// M-cycle sequencer: owns IR and step, runs the bus handshake and strobes commit
// when an M-cycle completes.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter opcode_t    RESET_OPCODE = 8'h00,
    parameter logic [2:0] MAX_STEP     = 3'd7
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   dec_done,
    input  logic                   dec_is_cond,
    input  logic [2:0]             dec_next_cond,
    input  logic                   dec_mem_rd,
    input  logic                   dec_mem_wr,
    input  logic                   flag_z,
    input  logic                   flag_c,
    cpu_sequencer_if.master        bus,
    output opcode_t                opcode,
    output logic [2:0]             step,
    output logic                   commit,
    output logic                   fetch_active,
    output logic                   trap
);

    seq_state_t state_r;
    cc_t        cc_s;
    logic       cond_ok_s;
    logic       req_s;
    logic       we_s;
    logic       complete_s;
    logic       incr_s;
    logic       overflow_s;
    logic [2:0] next_step_s;

    assign cc_s = cc_t'(opcode[4:3]);

    cc_eval u_cc_eval (
        .cc        (cc_s),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .satisfied (cond_ok_s)
    );

    // Handshake, completion and next-step selection for the current M-cycle.
    // rst_n gates req/commit so an access is abandoned the instant reset asserts.
    always_comb begin
        req_s        = 1'b0;
        we_s         = 1'b0;
        complete_s   = 1'b0;
        incr_s       = 1'b0;
        next_step_s  = step;
        fetch_active = 1'b0;
        case (state_r)
            BOOT: begin
                fetch_active = 1'b1;
                req_s        = rst_n;
                complete_s   = rst_n & bus.ack;
            end
            EXEC: begin
                if (dec_mem_rd | dec_mem_wr | dec_done) begin
                    req_s      = rst_n;
                    we_s       = dec_mem_wr;
                    complete_s = rst_n & bus.ack;
                end else begin
                    complete_s = rst_n;
                end
                if (dec_done) begin
                    next_step_s = 3'd0;
                end else if (dec_is_cond & ~cond_ok_s) begin
                    next_step_s = dec_next_cond;
                end else begin
                    next_step_s = step + 3'd1;
                    incr_s      = 1'b1;
                end
            end
            TRAP: begin
                req_s = 1'b0;
            end
            default: begin
                req_s = 1'b0;
            end
        endcase
        overflow_s = (state_r == EXEC) & complete_s & incr_s & (step == MAX_STEP);
        commit     = complete_s & ~overflow_s;
    end

    assign bus.req = req_s;
    assign bus.we  = req_s & we_s;

    // Sequencer state, IR, step counter and sticky trap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= BOOT;
            opcode  <= RESET_OPCODE;
            step    <= 3'd0;
            trap    <= 1'b0;
        end else begin
            case (state_r)
                BOOT: begin
                    if (complete_s) begin
                        opcode  <= bus.rdata;
                        step    <= 3'd0;
                        state_r <= EXEC;
                    end
                end
                EXEC: begin
                    if (overflow_s) begin
                        state_r <= TRAP;
                        trap    <= 1'b1;
                    end else if (complete_s) begin
                        step <= next_step_s;
                        if (dec_done) begin
                            opcode <= bus.rdata;
                        end
                    end
                end
                TRAP: begin
                    trap <= 1'b1;
                end
                default: begin
                    state_r <= TRAP;
                    trap    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed scoreboard bench for cpu_sequencer: boot, memory/internal steps,
// conditional stepping, trap and reset during an access.
module tb_cpu_sequencer;
    import cpu_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       dec_done;
    logic       dec_is_cond;
    logic [2:0] dec_next_cond;
    logic       dec_mem_rd;
    logic       dec_mem_wr;
    logic       flag_z;
    logic       flag_c;
    opcode_t    opcode;
    logic [2:0] step;
    logic       commit;
    logic       fetch_active;
    logic       trap;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string      tag;
        logic [7:0] op;
        logic [2:0] st;
        logic       tr;
    } exp_t;
    exp_t sb_q[$];

    cpu_sequencer_if bif ();

    cpu_sequencer #(.RESET_OPCODE(8'h00), .MAX_STEP(3'd7)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .dec_done      (dec_done),
        .dec_is_cond   (dec_is_cond),
        .dec_next_cond (dec_next_cond),
        .dec_mem_rd    (dec_mem_rd),
        .dec_mem_wr    (dec_mem_wr),
        .flag_z        (flag_z),
        .flag_c        (flag_c),
        .bus           (bif.master),
        .opcode        (opcode),
        .step          (step),
        .commit        (commit),
        .fetch_active  (fetch_active),
        .trap          (trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic d, input logic c, input logic [2:0] nc,
                       input logic rd, input logic wr, input logic ack, input logic [7:0] data);
        dec_done      = d;
        dec_is_cond   = c;
        dec_next_cond = nc;
        dec_mem_rd    = rd;
        dec_mem_wr    = wr;
        bif.ack       = ack;
        bif.rdata     = data;
    endtask

    // One clock: check handshake outputs before the edge, push the expected
    // post-edge state, then pop and compare it just after the edge.
    task automatic cyc(input string tag, input logic e_req, input logic e_we, input logic e_commit,
                       input logic [7:0] e_op, input logic [2:0] e_st, input logic e_tr);
        exp_t e;
        #2;
        chk({tag, ".req"}, 32'(bif.req), 32'(e_req));
        if (e_req) chk({tag, ".we"}, 32'(bif.we), 32'(e_we));
        chk({tag, ".commit"}, 32'(commit), 32'(e_commit));
        e.tag = tag; e.op = e_op; e.st = e_st; e.tr = e_tr;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({e.tag, ".opcode"}, 32'(opcode), 32'(e.op));
            chk({e.tag, ".step"},   32'(step),   32'(e.st));
            chk({e.tag, ".trap"},   32'(trap),   32'(e.tr));
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        flag_z = 1'b0;
        flag_c = 1'b0;
        drv(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 8'hFF);
        #2;
        chk("rst.req",    32'(bif.req),      32'd0);
        chk("rst.commit", 32'(commit),       32'd0);
        chk("rst.fetch",  32'(fetch_active), 32'd1);
        chk("rst.opcode", 32'(opcode),       32'h00);
        chk("rst.step",   32'(step),         32'd0);
        chk("rst.trap",   32'(trap),         32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drv(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00);

        // Boot fetch with two wait states.
        cyc("boot_w1", 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
        cyc("boot_w2", 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
        drv(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 8'h3E);
        cyc("boot_ack", 1'b1, 1'b0, 1'b1, 8'h3E, 3'd0, 1'b0);
        chk("boot.fetch_off", 32'(fetch_active), 32'd0);

        // LD r,n with zero waits: operand read then overlapped fetch.
        drv(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 8'h42);
        cyc("ld_s0", 1'b1, 1'b0, 1'b1, 8'h3E, 3'd1, 1'b0);
        drv(1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 8'h78);
        cyc("ld_s1", 1'b1, 1'b0, 1'b1, 8'h78, 3'd0, 1'b0);

        // Write with three waits; rd and wr both set so wr must win.
        drv(1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) cyc("wr_wait", 1'b1, 1'b1, 1'b0, 8'h78, 3'd0, 1'b0);
        bif.ack = 1'b1;
        cyc("wr_ack", 1'b1, 1'b1, 1'b1, 8'h78, 3'd1, 1'b0);

        // Conditional NZ on opcode 20.
        drv(1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 8'h20);
        cyc("ld_20", 1'b1, 1'b0, 1'b1, 8'h20, 3'd0, 1'b0);
        flag_z = 1'b1;
        drv(1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 8'h00);
        cyc("nz_fail", 1'b0, 1'b0, 1'b1, 8'h20, 3'd5, 1'b0);
        flag_z = 1'b0;
        cyc("nz_pass", 1'b0, 1'b0, 1'b1, 8'h20, 3'd6, 1'b0);

        // Conditional C on opcode 38.
        drv(1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 8'h38);
        cyc("ld_38", 1'b1, 1'b0, 1'b1, 8'h38, 3'd0, 1'b0);
        flag_c = 1'b0;
        drv(1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 8'h00);
        cyc("c_fail", 1'b0, 1'b0, 1'b1, 8'h38, 3'd2, 1'b0);
        flag_c = 1'b1;
        cyc("c_pass", 1'b0, 1'b0, 1'b1, 8'h38, 3'd3, 1'b0);

        // done and an unsatisfied condition together: done wins (C with flag_c=0).
        flag_c = 1'b0;
        drv(1'b1, 1'b1, 3'd5, 1'b1, 1'b0, 1'b1, 8'h00);
        cyc("done_wins", 1'b1, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0);

        // Runaway internal steps overflow into TRAP.
        drv(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 1; i <= 7; i++) cyc("run", 1'b0, 1'b0, 1'b1, 8'h00, 3'(i), 1'b0);
        cyc("ovf", 1'b0, 1'b0, 1'b0, 8'h00, 3'd7, 1'b1);
        drv(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 8'hAA);
        cyc("trap_hold", 1'b0, 1'b0, 1'b0, 8'h00, 3'd7, 1'b1);
        chk("trap.fetch", 32'(fetch_active), 32'd0);

        rst_n = 1'b0;
        #1;
        chk("trap_rst.trap",  32'(trap),         32'd0);
        chk("trap_rst.fetch", 32'(fetch_active), 32'd1);
        chk("trap_rst.step",  32'(step),         32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drv(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 8'hA0);
        cyc("reboot", 1'b1, 1'b0, 1'b1, 8'hA0, 3'd0, 1'b0);

        // Reset while a write is outstanding; the late ack must be ignored.
        drv(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 8'h00);
        cyc("wr2_wait", 1'b1, 1'b1, 1'b0, 8'hA0, 3'd0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst.req",    32'(bif.req), 32'd0);
        chk("mid_rst.commit", 32'(commit),  32'd0);
        chk("mid_rst.opcode", 32'(opcode),  32'h00);
        bif.ack   = 1'b1;
        bif.rdata = 8'hEE;
        cyc("late_ack", 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
        rst_n = 1'b1;
        drv(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00);
        cyc("reboot2_req", 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
        drv(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 8'h55);
        cyc("reboot2_ack", 1'b1, 1'b0, 1'b1, 8'h55, 3'd0, 1'b0);
        chk("sb.drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
